// File: rtl/matrix_tx_scheduler.sv
// matrix_tx_scheduler: round-robin row-major dump of NREQ matrix memories through one shared UART transmitter
module matrix_tx_scheduler #(
  parameter int NREQ = 3,
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [NREQ*DATA_W-1:0] mem_data,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_byte,
  input  logic                   tx_busy,
  output logic                   busy
);
  localparam int NEL = ROWS * COLS;
  localparam int PW = $clog2(NREQ);
  if (NEL > 2 ** ADDR_W) begin : g_size_check
    $error("ROWS*COLS does not fit in ADDR_W address bits");
  end
  typedef enum logic [3:0] {IDLE, ARB, READ, WAIT_DATA, START, WAIT_HI, WAIT_LO, NEXT, FIN} state_t;
  state_t state;
  logic [NREQ-1:0] pending;
  logic [PW-1:0] ptr, gidx, win;
  logic found;
  logic [ADDR_W-1:0] elem_cnt;
  logic [15:0] wd;
  logic lat;
  logic [1:0] bsync;
  // tx_busy comes from the slow baud domain, so bring it in through two flops
  always_ff @(posedge clk or posedge rst)
    if (rst) bsync <= '0;
    else bsync <= {bsync[0], tx_busy};
  // remember requests until their dump completes; a request during the done cycle queues another dump
  always_ff @(posedge clk or posedge rst)
    if (rst) pending <= '0;
    else pending <= (pending & ~done) | req;
  // first pending requester at or after the round-robin pointer
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (pending[(int'(ptr) + k) % NREQ]) begin
        win = PW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
  end
  // dump sequencer: read one element, hand it to the transmitter, repeat until the matrix is sent
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      elem_cnt <= '0;
      wd <= '0;
      lat <= 1'b0;
      grant <= '0;
      done <= '0;
      mem_rd <= '0;
      mem_addr <= '0;
      tx_start <= 1'b0;
      tx_byte <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (|pending) begin
            state <= ARB;
            busy <= 1'b1;
          end
        ARB:
          if (found) begin
            state <= READ;
            gidx <= win;
            grant <= NREQ'(1) << win;
            mem_rd <= NREQ'(1) << win;
            mem_addr <= elem_cnt;
            ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        READ: begin
          state <= WAIT_DATA;
          mem_rd <= '0;
          lat <= 1'b0;
        end
        WAIT_DATA:
          if (int'(lat) == RD_LAT - 1) begin
            state <= START;
            tx_byte <= mem_data[int'(gidx)*DATA_W +: DATA_W];
            tx_start <= 1'b1;
            wd <= '0;
          end else lat <= 1'b1;
        START:
          if (bsync[1] || &wd) begin
            state <= bsync[1] ? WAIT_HI : NEXT;
            tx_start <= 1'b0;
          end else wd <= wd + 1'b1;
        WAIT_HI: if (!bsync[1]) state <= WAIT_LO;
        WAIT_LO: state <= NEXT;
        NEXT: begin
          elem_cnt <= elem_cnt + 1'b1;
          if (elem_cnt == ADDR_W'(NEL - 1)) begin
            state <= FIN;
            done <= grant;
          end else begin
            state <= READ;
            mem_rd <= grant;
            mem_addr <= elem_cnt + 1'b1;
          end
        end
        FIN: begin
          state <= ARB;
          done <= '0;
          grant <= '0;
          elem_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// tb_matrix_tx_scheduler: randomized scoreboard bench for matrix_tx_scheduler
module tb_matrix_tx_scheduler;
  typedef struct {
    logic [7:0] b;
    int r;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req;
  logic [2:0] done, grant, mem_rd;
  logic [5:0] mem_addr;
  logic [23:0] mem_data = '0;
  logic tx_start, tx_busy, busy;
  logic [7:0] tx_byte;
  logic [7:0] mem [0:2][0:3];
  exp_t exp_q[$];
  int done_q[$];
  exp_t e;
  int checks = 0, passes = 0;
  int rises = 0, dones = 0, run = 0, maxrun = 0, ignore = 0, mptr = 0;
  int tph = 0, dly = 0;
  int base_r, base_d;
  logic ps = 1'b0;
  matrix_tx_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .busy(busy)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 3; i++) if (mem_rd[i]) mem_data[i*8 +: 8] <= mem[i][mem_addr[1:0]];
  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask
  function automatic int pick(input logic [2:0] pend);
    for (int k = 0; k < 3; k++) if (pend[(mptr + k) % 3]) return (mptr + k) % 3;
    return -1;
  endfunction
  task automatic serve(input int r);
    for (int a = 0; a < 4; a++) exp_q.push_back('{mem[r][a], r});
    done_q.push_back(r);
    mptr = (r + 1) % 3;
  endtask
  task automatic rr_batch(input logic [2:0] m);
    logic [2:0] pend = m;
    while (pend != 0) begin
      int r = pick(pend);
      serve(r);
      pend[r] = 1'b0;
    end
  endtask
  task automatic randomize_mem();
    for (int i = 0; i < 3; i++) for (int a = 0; a < 4; a++) mem[i][a] = 8'($urandom);
  endtask
  task automatic pulse(input logic [2:0] m);
    req = m;
    @(negedge clk);
    req = 3'b000;
  endtask
  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " completes"}, longint'(n < budget), 1);
    if (n >= budget) begin
      exp_q.delete();
      done_q.delete();
    end
  endtask
  task automatic wait_grant(input logic [2:0] g, input string nm);
    int n = 0;
    while (grant !== g && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, grant, g);
  endtask
  // transmitter model: random delays before busy and before release; can ignore bytes to exercise the watchdog
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        tph = 0;
      end else
        case (tph)
          0: if (tx_start) begin
            if (ignore > 0) tph = 4;
            else begin
              dly = $urandom_range(0, 3);
              tph = 1;
            end
          end
          1: if (dly == 0) begin
            tx_busy = 1'b1;
            tph = 2;
          end else dly--;
          2: if (!tx_start) begin
            dly = $urandom_range(1, 5);
            tph = 3;
          end
          3: if (dly == 0) begin
            tx_busy = 1'b0;
            tph = 0;
          end else dly--;
          4: if (!tx_start) begin
            ignore--;
            tph = 0;
          end
          default: tph = 0;
        endcase
    end
  end
  // monitor: each tx_start rise and done pulse is checked against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      ps = 1'b0;
      run = 0;
    end else begin
      if (tx_start && !ps) begin
        rises++;
        if (exp_q.size() == 0) chk("unexpected tx_start", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", tx_byte, e.b);
          chk("grant during byte", grant, 1 << e.r);
        end
      end
      if (tx_start) run++;
      else if (ps) begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      ps = tx_start;
      for (int i = 0; i < 3; i++)
        if (done[i]) begin
          dones++;
          if (done_q.size() == 0) chk("unexpected done", done_q.size(), 1);
          else chk("done index", i, done_q.pop_front());
        end
      if (|mem_rd) chk("mem_rd matches grant", mem_rd, grant);
    end
  end
  initial begin
    #950000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    req = 3'b000;
    randomize_mem();
    repeat (3) @(negedge clk);
    chk("reset grant", grant, 0);
    chk("reset done", done, 0);
    chk("reset mem_rd", mem_rd, 0);
    chk("reset tx_start", tx_start, 0);
    chk("reset busy", busy, 0);
    chk("reset tx_byte", tx_byte, 0);
    chk("reset mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    mem[1][0] = 8'h11; mem[1][1] = 8'h22; mem[1][2] = 8'h33; mem[1][3] = 8'h44;
    base_r = rises; base_d = dones;
    rr_batch(3'b010);
    pulse(3'b010);
    wait_idle(2000, "single dump");
    chk("single byte count", rises - base_r, 4);
    chk("single done count", dones - base_d, 1);
    chk("single busy after", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    randomize_mem();
    base_r = rises; base_d = dones;
    rr_batch(3'b111);
    pulse(3'b111);
    wait_idle(4000, "simultaneous");
    chk("simultaneous byte count", rises - base_r, 12);
    chk("simultaneous done count", dones - base_d, 3);
    randomize_mem();
    serve(pick(3'b001));
    serve(pick(3'b101));
    serve(pick(3'b001));
    req = 3'b001;
    wait_grant(3'b001, "fair first grant");
    req = 3'b101;
    @(negedge clk);
    req = 3'b001;
    wait_grant(3'b100, "fair second grant");
    wait_grant(3'b001, "fair third grant");
    req = 3'b000;
    wait_idle(4000, "fairness");
    randomize_mem();
    for (int a = 0; a < 4; a++) mem[0][a] = 8'h00;
    base_r = rises;
    rr_batch(3'b001);
    pulse(3'b001);
    wait_idle(2000, "zero data");
    chk("zero byte count", rises - base_r, 4);
    for (int t = 0; t < 6; t++) begin
      logic [2:0] m = 3'($urandom_range(1, 7));
      randomize_mem();
      rr_batch(m);
      pulse(m);
      wait_idle(4000, "random batch");
    end
    randomize_mem();
    base_r = rises; base_d = dones;
    for (int a = 0; a < 2; a++) exp_q.push_back('{mem[1][a], 1});
    pulse(3'b010);
    for (int n = 0; n < 2000 && rises - base_r < 2; n++) @(negedge clk);
    for (int n = 0; n < 2000 && tx_start; n++) @(negedge clk);
    chk("reached second byte", rises - base_r, 2);
    rst = 1'b1;
    #1;
    chk("abort grant", grant, 0);
    chk("abort done", done, 0);
    chk("abort mem_rd", mem_rd, 0);
    chk("abort tx_start", tx_start, 0);
    chk("abort busy", busy, 0);
    chk("abort tx_byte", tx_byte, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort scoreboard drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    repeat (20) @(negedge clk);
    chk("post-abort idle busy", busy, 0);
    chk("post-abort idle grant", grant, 0);
    chk("post-abort no bytes", rises - base_r, 2);
    chk("post-abort no done", dones - base_d, 0);
    randomize_mem();
    base_r = rises; base_d = dones;
    ignore = 1;
    maxrun = 0;
    rr_batch(3'b100);
    pulse(3'b100);
    wait_idle(70000, "stuck transmitter");
    chk("watchdog start length", maxrun, 65536);
    chk("stuck byte count", rises - base_r, 4);
    chk("stuck done count", dones - base_d, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
